// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32 sequencer: instruction classes, FSM
// states and trap causes, plus small class-decode helpers.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_SYSTEM, OP_ILLEGAL
  } op_class_t;

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE,
    S_MEM_REQ, S_MEM_WAIT, S_WRITEBACK, S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE, TRAP_ILLEGAL, TRAP_MISALIGNED, TRAP_BUS_TIMEOUT
  } trap_cause_t;

  function automatic logic is_mem(op_class_t c);
    return c inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic logic writes_rd(op_class_t c);
    return c inside {OP_ALU, OP_LOAD, OP_JUMP, OP_SYSTEM};
  endfunction

  // The unnamed encoding 3'b111 is treated like ILLEGAL.
  function automatic logic is_legal(op_class_t c);
    return c inside {OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_SYSTEM};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_bus_timer.sv
// Memory-wait watchdog: counts cycles spent waiting on a bus handshake and
// flags the TIMEOUT-th cycle. TIMEOUT=0 disables expiry.
module multicycle_ctrl_bus_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [W-1:0] LAST  = LAST_I[W-1:0];

  logic [W-1:0] cnt_q;

  // cnt_q holds the number of already-elapsed wait cycles, so the current
  // cycle is the TIMEOUT-th one when cnt_q == TIMEOUT-1.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)           cnt_q <= '0;
    else if (en_i && cnt_q != LAST) cnt_q <= cnt_q + W'(1);
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 main sequencer: fetch/decode/execute/mem/writeback FSM with
// bus handshakes, stage enables, retire counting and trap/halt.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  op_class_t         op_class_i,
  input  logic              rd_nz_i,
  input  logic              branch_taken_i,
  input  logic              misaligned_i,
  output logic              imem_req_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  output logic              fetch_en_o,
  output logic              decode_en_o,
  output logic              execute_en_o,
  output logic              mem_en_o,
  output logic              rf_we_o,
  output logic              pc_en_o,
  output logic              pc_sel_o,
  output logic              retire_o,
  output logic              halt_o,
  output trap_cause_t       trap_cause_o,
  output logic [CNT_W-1:0]  instret_o
);

  ctrl_state_t state_q, state_n;
  trap_cause_t cause_q, cause_n;
  logic        taken_q;
  logic [CNT_W-1:0] instret_q;
  logic        tmr_clear, tmr_en, tmr_expired;
  logic        imem_done, dmem_first, dmem_done;

  assign imem_done  = imem_gnt_i & imem_rvalid_i;
  assign dmem_first = dmem_gnt_i & dmem_rvalid_i;
  assign dmem_done  = (state_q == S_MEM_REQ) ? dmem_first : dmem_rvalid_i;

  // One budget covers req+wait of an access; it restarts only on a fresh access.
  assign tmr_en    = state_q inside {S_FETCH, S_FETCH_WAIT, S_MEM_REQ, S_MEM_WAIT};
  assign tmr_clear = (state_n == S_FETCH   && state_q != S_FETCH) ||
                     (state_n == S_MEM_REQ && state_q != S_MEM_REQ);

  multicycle_ctrl_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      cause_q   <= TRAP_NONE;
      taken_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_q != S_TRAP && state_n == S_TRAP) cause_q <= cause_n;
      if (state_q == S_EXECUTE) taken_q <= branch_taken_i;
      if (state_q == S_WRITEBACK) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Completion in the expiring cycle takes priority over the timeout.
  always_comb begin
    state_n = state_q;
    cause_n = TRAP_NONE;
    case (state_q)
      S_FETCH:
        if (imem_done)        state_n = S_DECODE;
        else if (tmr_expired) begin state_n = S_TRAP; cause_n = TRAP_BUS_TIMEOUT; end
        else if (imem_gnt_i)  state_n = S_FETCH_WAIT;
      S_FETCH_WAIT:
        if (imem_rvalid_i)    state_n = S_DECODE;
        else if (tmr_expired) begin state_n = S_TRAP; cause_n = TRAP_BUS_TIMEOUT; end
      S_DECODE:
        if (!is_legal(op_class_i)) begin state_n = S_TRAP; cause_n = TRAP_ILLEGAL; end
        else                       state_n = S_EXECUTE;
      S_EXECUTE:
        if (!is_mem(op_class_i)) state_n = S_WRITEBACK;
        else if (misaligned_i)   begin state_n = S_TRAP; cause_n = TRAP_MISALIGNED; end
        else                     state_n = S_MEM_REQ;
      S_MEM_REQ, S_MEM_WAIT:
        if (dmem_done)        state_n = S_WRITEBACK;
        else if (tmr_expired) begin state_n = S_TRAP; cause_n = TRAP_BUS_TIMEOUT; end
        else if (state_q == S_MEM_REQ && dmem_gnt_i) state_n = S_MEM_WAIT;
      S_WRITEBACK: state_n = S_FETCH;
      S_TRAP:      state_n = S_TRAP;
      default:     state_n = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    fetch_en_o   = 1'b0;
    decode_en_o  = 1'b0;
    execute_en_o = 1'b0;
    mem_en_o     = 1'b0;
    rf_we_o      = 1'b0;
    pc_en_o      = 1'b0;
    pc_sel_o     = 1'b0;
    retire_o     = 1'b0;
    halt_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH:      begin imem_req_o = 1'b1; fetch_en_o = imem_done; end
        S_FETCH_WAIT: fetch_en_o = imem_rvalid_i;
        S_DECODE:     decode_en_o = 1'b1;
        S_EXECUTE:    execute_en_o = 1'b1;
        S_MEM_REQ: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (op_class_i == OP_STORE);
          mem_en_o   = dmem_done & (op_class_i == OP_LOAD);
        end
        S_MEM_WAIT:   mem_en_o = dmem_done & (op_class_i == OP_LOAD);
        S_WRITEBACK: begin
          pc_en_o  = 1'b1;
          retire_o = 1'b1;
          rf_we_o  = rd_nz_i & writes_rd(op_class_i);
          pc_sel_o = (op_class_i == OP_JUMP) | ((op_class_i == OP_BRANCH) & taken_q);
        end
        S_TRAP:       halt_o = 1'b1;
        default:      ;
      endcase
    end
  end

  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of single-instruction vectors plus
// hand sequences for reset, stale response, timeouts, traps and mid-op reset.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0, rst = 1'b1;
  op_class_t op_class = OP_ALU;
  logic rd_nz = 1'b0, taken = 1'b0, mis = 1'b0;
  logic imem_gnt = 1'b0, imem_rvalid = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic imem_req_o, dmem_req_o, dmem_we_o, fetch_en_o, decode_en_o, execute_en_o;
  logic mem_en_o, rf_we_o, pc_en_o, pc_sel_o, retire_o, halt_o;
  trap_cause_t trap_cause_o;
  logic [CNT_W-1:0] instret_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .op_class_i(op_class), .rd_nz_i(rd_nz),
    .branch_taken_i(taken), .misaligned_i(mis),
    .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid), .fetch_en_o(fetch_en_o), .decode_en_o(decode_en_o),
    .execute_en_o(execute_en_o), .mem_en_o(mem_en_o), .rf_we_o(rf_we_o),
    .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o), .retire_o(retire_o), .halt_o(halt_o),
    .trap_cause_o(trap_cause_o), .instret_o(instret_o)
  );

  typedef struct {
    op_class_t   op;
    bit          rd_nz, tk, mis, nogi;
    int          ilat, dlat;
    int          e_cyc;
    bit          e_rf, e_pc, e_we;
    int          e_men;
    trap_cause_t e_cause;
  } vec_t;

  typedef struct {
    int ret, halt, men, stray;
    bit rf, pc, we;
  } res_t;

  int total = 0, bad = 0, exp_cnt = 0;
  vec_t vt[13];
  vec_t tv[6];
  vec_t abort_v;
  res_t r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Starts in the first FETCH cycle; responds to requests with the vector's latencies.
  task automatic run(input vec_t v, input int abort_at, output res_t o);
    int ig, dg;
    o = '{default:0};
    ig = -1; dg = -1;
    op_class = v.op; rd_nz = v.rd_nz;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (imem_req_o && !v.nogi) begin imem_gnt = 1'b1; ig = c; end
      if (ig > 0 && c == ig + v.ilat) imem_rvalid = 1'b1;
      if (dmem_req_o) begin dmem_gnt = 1'b1; dg = c; end
      if (dg > 0 && c == dg + v.dlat) dmem_rvalid = 1'b1;
      // Garbage outside EXECUTE exposes any use of these after their valid cycle.
      taken = execute_en_o ? v.tk  : !v.tk;
      mis   = execute_en_o ? v.mis : 1'b1;
      #1;
      if (dmem_req_o) o.we |= dmem_we_o;
      if (mem_en_o) o.men++;
      if (!retire_o && (rf_we_o || pc_en_o || pc_sel_o)) o.stray++;
      if (retire_o) begin o.ret = c; o.rf = rf_we_o; o.pc = pc_sel_o; end
      if (halt_o) o.halt = c;
      if (retire_o || halt_o || c == abort_at) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst outputs", {imem_req_o, dmem_req_o, dmem_we_o, fetch_en_o, decode_en_o,
        execute_en_o, mem_en_o, rf_we_o, pc_en_o, pc_sel_o, retire_o, halt_o}, 0);
    chk("rst instret", 64'(instret_o), 0);
    chk("rst cause", 64'(trap_cause_o), 64'(TRAP_NONE));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("first imem_req", 64'(imem_req_o), 1);
    exp_cnt = 0;
  endtask

  task automatic check_cnt(input string nm);
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk(nm, 64'(instret_o), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op         rd    tk    mis   nogi  il  dl  cyc rf    pc    we   men cause
    vt[0]  = '{OP_ALU,    1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  4, 1'b1, 1'b0, 1'b0, 0, TRAP_NONE};
    vt[1]  = '{OP_LOAD,   1'b1, 1'b0, 1'b0, 1'b0, 0,  3,  8, 1'b1, 1'b0, 1'b0, 1, TRAP_NONE};
    vt[2]  = '{OP_STORE,  1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  5, 1'b0, 1'b0, 1'b1, 0, TRAP_NONE};
    vt[3]  = '{OP_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0, 0,  0,  4, 1'b0, 1'b1, 1'b0, 0, TRAP_NONE};
    vt[4]  = '{OP_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  4, 1'b0, 1'b0, 1'b0, 0, TRAP_NONE};
    vt[5]  = '{OP_JUMP,   1'b0, 1'b0, 1'b0, 1'b0, 0,  0,  4, 1'b0, 1'b1, 1'b0, 0, TRAP_NONE};
    vt[6]  = '{OP_JUMP,   1'b1, 1'b0, 1'b0, 1'b0, 1,  0,  5, 1'b1, 1'b1, 1'b0, 0, TRAP_NONE};
    vt[7]  = '{OP_SYSTEM, 1'b1, 1'b0, 1'b1, 1'b0, 0,  0,  4, 1'b1, 1'b0, 1'b0, 0, TRAP_NONE};
    vt[8]  = '{OP_ALU,    1'b0, 1'b0, 1'b0, 1'b0, 2,  0,  6, 1'b0, 1'b0, 1'b0, 0, TRAP_NONE};
    vt[9]  = '{OP_LOAD,   1'b1, 1'b0, 1'b0, 1'b0, 1,  1,  7, 1'b1, 1'b0, 1'b0, 1, TRAP_NONE};
    vt[10] = '{OP_STORE,  1'b0, 1'b0, 1'b0, 1'b0, 0, 15, 20, 1'b0, 1'b0, 1'b1, 0, TRAP_NONE};
    vt[11] = '{OP_ALU,    1'b1, 1'b0, 1'b0, 1'b0, 15, 0, 19, 1'b1, 1'b0, 1'b0, 0, TRAP_NONE};
    vt[12] = '{OP_LOAD,   1'b0, 1'b1, 1'b0, 1'b0, 0,  0,  5, 1'b0, 1'b0, 1'b0, 1, TRAP_NONE};

    tv[0]  = '{OP_ALU,    1'b1, 1'b0, 1'b0, 1'b1, 0,  0, 17, 1'b0, 1'b0, 1'b0, 0, TRAP_BUS_TIMEOUT};
    tv[1]  = '{OP_ALU,    1'b1, 1'b0, 1'b0, 1'b0, 16, 0, 17, 1'b0, 1'b0, 1'b0, 0, TRAP_BUS_TIMEOUT};
    tv[2]  = '{OP_LOAD,   1'b1, 1'b0, 1'b0, 1'b0, 0, 16, 20, 1'b0, 1'b0, 1'b0, 0, TRAP_BUS_TIMEOUT};
    tv[3]  = '{OP_ILLEGAL,1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  3, 1'b0, 1'b0, 1'b0, 0, TRAP_ILLEGAL};
    tv[4]  = '{OP_STORE,  1'b1, 1'b0, 1'b1, 1'b0, 0,  0,  4, 1'b0, 1'b0, 1'b0, 0, TRAP_MISALIGNED};
    tv[5]  = '{OP_LOAD,   1'b1, 1'b0, 1'b1, 1'b0, 0,  0,  4, 1'b0, 1'b0, 1'b0, 0, TRAP_MISALIGNED};

    abort_v = '{OP_LOAD,  1'b1, 1'b0, 1'b0, 1'b0, 0, 10,  0, 1'b0, 1'b0, 1'b0, 0, TRAP_NONE};

    do_reset();
    foreach (vt[i]) begin
      run(vt[i], 0, r);
      chk($sformatf("v%0d retire cycle", i), 64'(r.ret), 64'(vt[i].e_cyc));
      chk($sformatf("v%0d rf_we", i), 64'(r.rf), 64'(vt[i].e_rf));
      chk($sformatf("v%0d pc_sel", i), 64'(r.pc), 64'(vt[i].e_pc));
      chk($sformatf("v%0d dmem_we", i), 64'(r.we), 64'(vt[i].e_we));
      chk($sformatf("v%0d mem_en count", i), 64'(r.men), 64'(vt[i].e_men));
      chk($sformatf("v%0d stray strobes", i), 64'(r.stray), 0);
      chk($sformatf("v%0d halt", i), 64'(r.halt), 0);
      check_cnt($sformatf("v%0d instret", i));
    end

    // instret wraps 15 -> 0 with a 4-bit counter
    for (int k = 0; k < 3; k++) begin
      run(vt[0], 0, r);
      chk($sformatf("wrap%0d retire cycle", k), 64'(r.ret), 4);
      check_cnt($sformatf("wrap%0d instret", k));
    end

    // rvalid without gnt is a stale response and must not advance fetch
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    #1 chk("stale fetch_en", 64'(fetch_en_o), 0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    chk("stale still fetching", 64'(imem_req_o), 1);
    chk("stale no decode", 64'(decode_en_o), 0);
    run(vt[0], 0, r);
    chk("stale then alu retire", 64'(r.ret), 4);
    check_cnt("stale instret");

    foreach (tv[i]) begin
      do_reset();
      run(tv[i], 0, r);
      chk($sformatf("t%0d halt cycle", i), 64'(r.halt), 64'(tv[i].e_cyc));
      chk($sformatf("t%0d no retire", i), 64'(r.ret), 0);
      chk($sformatf("t%0d cause", i), 64'(trap_cause_o), 64'(tv[i].e_cause));
      chk($sformatf("t%0d dmem_we", i), 64'(r.we), 64'(tv[i].e_we));
      chk($sformatf("t%0d mem_en", i), 64'(r.men), 0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("t%0d halt held", i), 64'(halt_o), 1);
      chk($sformatf("t%0d quiet", i), {imem_req_o, dmem_req_o, retire_o, rf_we_o, pc_en_o}, 0);
      chk($sformatf("t%0d cause held", i), 64'(trap_cause_o), 64'(tv[i].e_cause));
      chk($sformatf("t%0d instret", i), 64'(instret_o), 0);
    end

    // reset while a load sits in MEM_WAIT abandons it
    do_reset();
    run(vt[0], 0, r);
    chk("mid pre retire", 64'(r.ret), 4);
    check_cnt("mid pre instret");
    run(abort_v, 6, r);
    chk("mid aborted no retire", 64'(r.ret), 0);
    chk("mid in mem wait", 64'(dmem_req_o | retire_o | halt_o), 0);
    do_reset();
    run(vt[0], 0, r);
    chk("mid post retire", 64'(r.ret), 4);
    chk("mid post rf_we", 64'(r.rf), 1);
    check_cnt("mid post instret");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
